tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
- Central timing controller: one free-running clk domain, produces single-cycle clock-enable strobes instead of derived clocks.
- Strobes: pixel enable, 7-segment scan enable, and a game tick with runtime-programmable period and pause/single-step control.
- Sits between the board clock and the VGA, segment-scan and game-logic blocks. The game FSM reconfigures game speed through a valid/ready handshake.

Parameters:
- PIX_DIV, 4, pixel strobe period in clk cycles; ≥2.
- SEG_DIV_LOG2, 18, seg strobe period = 2^SEG_DIV_LOG2 cycles.
- GAME_W, 32, game period register width.
- GAME_DEFAULT, 49999999, reset game period-minus-one (2 Hz tick at 100 MHz).

Ports:
- clk  in  1  master clock, 100 MHz
- clr_n  in  1  asynchronous active-low reset
- pause_req  in  1  level; 1 = hold game tick
- step_req  in  1  rising edge while paused = one game tick
- cfg_valid  in  1  new period offered
- cfg_period  in  GAME_W  new period-minus-one
- cfg_ready  out  1  = ~cfg_pending
- cfg_pending  out  1  accepted period not yet applied
- pix_tick  out  1  one-cycle strobe every PIX_DIV cycles
- seg_tick  out  1  one-cycle strobe every 2^SEG_DIV_LOG2 cycles
- game_tick  out  1  one-cycle game strobe
- paused  out  1  1 in PAUSED or STEP

Behaviour:
- Reset (clr_n=0, async): all counters 0, period=GAME_DEFAULT, state RUN, all ticks 0, cfg_pending 0 (cfg_ready 1), step edge register 0, paused 0.
- pix/seg counters are free-running mod PIX_DIV / 2^SEG_DIV_LOG2 and are unaffected by pause or cfg.
- Tick registration: tick registered high the cycle after the counter holds its terminal value. First pix_tick at cycle PIX_DIV after reset release.
- Game counter gcnt (GAME_W):
  - In RUN, gcnt increments.
  - When gcnt==period, gcnt←0 and game_tick registered high next cycle.
  - Result: game_tick interval is period+1 cycles. period=0 means game_tick every cycle.
- FSM:
  - RUN→PAUSED when pause_req=1. gcnt holds its value; no tick is issued that cycle even if gcnt==period.
  - PAUSED→RUN when pause_req=0. gcnt resumes from the held value.
  - PAUSED→STEP on a registered rising edge of step_req.
  - STEP: game_tick=1 for exactly one cycle, gcnt←0, then →PAUSED, or →RUN if pause_req=0.
  - step_req in RUN is ignored. step_req held high gives only one step.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready. cfg_period is latched into shadow and cfg_pending←1.
  - In RUN, shadow→period on the cycle gcnt wraps (gcnt==period). cfg_pending clears the next cycle.
  - In PAUSED/STEP, apply on the next cycle with gcnt←0.
  - No second accept while pending (cfg_ready=0).
  - Shrinking period below the current gcnt cannot miss wrap, because it is applied only at the boundary or while paused with gcnt cleared.
- Reset mid-operation: immediate return to reset values. Any pending config is discarded.

Optional Feature:
- Macro TICK_CLKOUT_EN. When defined, adds outputs dclk, segclk, gameclk (1 bit each) for legacy consumers:
  - dclk = pix counter MSB.
  - segclk = seg counter MSB.
  - gameclk = register toggled on every game_tick (period 2·(period+1) cycles).
  - All three are 0 in reset.
- When undefined, these ports and their registers do not exist. Strobe behaviour is identical either way.

Decomposition:
- Package tick_pkg: FSM state encoding (RUN, PAUSED, STEP), GAME_W, GAME_DEFAULT constant.
- Sub-module tick_div (parameter DIV): free-running modulo counter with registered one-cycle tick and MSB output. Instantiated for pix and seg.
- Game counter, FSM and handshake stay in the top.

Test Plan (sim params PIX_DIV=4, SEG_DIV_LOG2=4, GAME_DEFAULT=9):
- Release reset, run 100 cycles → pix_tick at cycles 4,8,…; seg_tick every 16; game_tick every 10, first at cycle 10. paused=0, cfg_ready=1.
- Offer cfg_period=3 mid-interval → cfg_ready drops 1 cycle later. Current 10-cycle interval completes, then ticks every 4. cfg_pending clears the cycle after wrap.
- pause_req=1 at gcnt=5 for 20 cycles → no game_tick, paused=1. Release → next game_tick exactly 5 cycles later. pix/seg continue.
- While paused, pulse step_req three times, one held high 10 cycles → exactly three single-cycle game_ticks, gcnt=0 after each.
- cfg_period=0 in RUN → after wrap, game_tick high every cycle. Assert clr_n=0 mid-stream → all outputs 0 immediately, period back to 9.
- With TICK_CLKOUT_EN: dclk period 4 cycles, segclk period 16, gameclk toggles on each game_tick (period 20 at default).

Source files
------------

// File: rtl/tick_pkg.sv
// tick_pkg: shared FSM encoding and game-period defaults for the tick scheduler.
package tick_pkg;
  localparam int GAME_W = 32;
  localparam logic [31:0] GAME_DEFAULT = 32'd49999999;
  typedef enum logic [1:0] {ST_RUN, ST_PAUSED, ST_STEP} state_t;
endpackage

// File: rtl/tick_div.sv
// tick_div: free-running modulo-DIV counter with a registered one-cycle tick.
// With TICK_CLKOUT_EN defined the counter MSB is also exported as a square wave.
module tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic clr_n,
  output logic o_tick
`ifdef TICK_CLKOUT_EN
  ,
  output logic o_msb
`endif
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] r_cnt;
  logic w_last;
  assign w_last = r_cnt == W'(DIV - 1);
`ifdef TICK_CLKOUT_EN
  assign o_msb = r_cnt[W-1];
`endif
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_cnt  <= '0;
      o_tick <= 1'b0;
    end else begin
      r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      o_tick <= w_last;
    end
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: pixel, segment-scan and pausable/reprogrammable game clock-enable strobes.
// Define TICK_CLKOUT_EN to add the legacy square-wave outputs dclk, segclk and gameclk.
module tick_scheduler
  import tick_pkg::state_t, tick_pkg::ST_RUN, tick_pkg::ST_PAUSED, tick_pkg::ST_STEP;
#(
  parameter int PIX_DIV = 4,
  parameter int SEG_DIV_LOG2 = 18,
  parameter int GAME_W = tick_pkg::GAME_W,
  parameter logic [GAME_W-1:0] GAME_DEFAULT = GAME_W'(tick_pkg::GAME_DEFAULT)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              pause_req,
  input  logic              step_req,
  input  logic              cfg_valid,
  input  logic [GAME_W-1:0] cfg_period,
  output logic              cfg_ready,
  output logic              cfg_pending,
  output logic              pix_tick,
  output logic              seg_tick,
  output logic              game_tick,
  output logic              paused
`ifdef TICK_CLKOUT_EN
  ,
  output logic              dclk,
  output logic              segclk,
  output logic              gameclk
`endif
);
  state_t r_state;
  logic [GAME_W-1:0] r_gcnt, r_period, r_shadow;
  logic r_pending, r_step_q, r_game_tick;
  logic w_step_edge, w_wrap;
  assign w_step_edge = step_req & ~r_step_q;
  assign w_wrap      = r_gcnt == r_period;
  assign cfg_pending = r_pending;
  assign cfg_ready   = ~r_pending;
  assign game_tick   = r_game_tick;
  assign paused      = r_state != ST_RUN;

  tick_div #(.DIV(PIX_DIV)) u_pix (
    .clk    (clk),
    .clr_n  (clr_n),
    .o_tick (pix_tick)
`ifdef TICK_CLKOUT_EN
    ,
    .o_msb  (dclk)
`endif
  );

  tick_div #(.DIV(2 ** SEG_DIV_LOG2)) u_seg (
    .clk    (clk),
    .clr_n  (clr_n),
    .o_tick (seg_tick)
`ifdef TICK_CLKOUT_EN
    ,
    .o_msb  (segclk)
`endif
  );

  // A new period only lands at an interval boundary or while paused with gcnt cleared,
  // so gcnt can never overshoot a shrunken period.
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_state     <= ST_RUN;
      r_gcnt      <= '0;
      r_period    <= GAME_DEFAULT;
      r_shadow    <= '0;
      r_pending   <= 1'b0;
      r_step_q    <= 1'b0;
      r_game_tick <= 1'b0;
    end else begin
      r_step_q    <= step_req;
      r_game_tick <= 1'b0;
      if (cfg_valid && !r_pending) begin
        r_shadow  <= cfg_period;
        r_pending <= 1'b1;
      end
      case (r_state)
        ST_RUN:
          if (pause_req) r_state <= ST_PAUSED;
          else if (w_wrap) begin
            r_gcnt      <= '0;
            r_game_tick <= 1'b1;
            if (r_pending) begin
              r_period  <= r_shadow;
              r_pending <= 1'b0;
            end
          end else r_gcnt <= r_gcnt + 1'b1;
        ST_PAUSED: begin
          if (r_pending) begin
            r_period  <= r_shadow;
            r_pending <= 1'b0;
            r_gcnt    <= '0;
          end
          if (!pause_req) r_state <= ST_RUN;
          else if (w_step_edge) begin
            r_state     <= ST_STEP;
            r_game_tick <= 1'b1;
            r_gcnt      <= '0;
          end
        end
        ST_STEP: begin
          if (r_pending) begin
            r_period  <= r_shadow;
            r_pending <= 1'b0;
            r_gcnt    <= '0;
          end
          r_state <= pause_req ? ST_PAUSED : ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end

`ifdef TICK_CLKOUT_EN
  logic r_gameclk;
  assign gameclk = r_gameclk;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_gameclk <= 1'b0;
    else r_gameclk <= r_gameclk ^ r_game_tick;
`endif
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: table-driven, hand-written and randomized checks of tick_scheduler
// against an interval-counting reference model (PIX_DIV=4, SEG_DIV_LOG2=4, GAME_DEFAULT=9).
module tb_tick_scheduler;
  localparam int PIX_DIV = 4;
  localparam int SEG_DIV_LOG2 = 4;
  localparam int SEG_DIV = 1 << SEG_DIV_LOG2;
  localparam int GAME_W = 32;
  localparam int GDEF = 9;

  logic clk = 1'b0, clr_n = 1'b0, pause_req = 1'b0, step_req = 1'b0, cfg_valid = 1'b0;
  logic [GAME_W-1:0] cfg_period = '0;
  logic cfg_ready, cfg_pending, pix_tick, seg_tick, game_tick, paused;
`ifdef TICK_CLKOUT_EN
  logic dclk, segclk, gameclk;
`endif
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  tick_scheduler #(
    .PIX_DIV(PIX_DIV), .SEG_DIV_LOG2(SEG_DIV_LOG2), .GAME_W(GAME_W), .GAME_DEFAULT(32'(GDEF))
  ) dut (
    .clk(clk), .clr_n(clr_n), .pause_req(pause_req), .step_req(step_req),
    .cfg_valid(cfg_valid), .cfg_period(cfg_period), .cfg_ready(cfg_ready),
    .cfg_pending(cfg_pending), .pix_tick(pix_tick), .seg_tick(seg_tick),
    .game_tick(game_tick), .paused(paused)
`ifdef TICK_CLKOUT_EN
    , .dclk(dclk), .segclk(segclk), .gameclk(gameclk)
`endif
  );

  // Reference model: edges since reset, mode (0 run, 1 paused, 2 step), and the number of
  // counted run cycles in the current game interval, which lasts per+1 counted cycles.
  int m_cyc, m_mode, m_cnt, m_per, m_shadow;
  bit m_pend, m_prev_step, m_game, m_gclk;

  task automatic model_reset();
    m_cyc = 0; m_mode = 0; m_cnt = 0; m_per = GDEF; m_shadow = 0;
    m_pend = 0; m_prev_step = 0; m_game = 0; m_gclk = 0;
  endtask

  task automatic model_step(input bit p, input bit s, input bit v, input int per);
    bit rise, acc;
    rise = s && !m_prev_step;
    m_prev_step = s;
    acc = v && !m_pend;
    m_game = 0;
    m_cyc++;
    if (m_mode == 0) begin
      if (p) m_mode = 1;
      else begin
        m_cnt++;
        if (m_cnt == m_per + 1) begin
          m_game = 1; m_cnt = 0;
          if (m_pend) begin m_per = m_shadow; m_pend = 0; end
        end
      end
    end else begin
      if (m_pend) begin m_per = m_shadow; m_pend = 0; m_cnt = 0; end
      if (m_mode == 2) m_mode = p ? 1 : 0;
      else if (!p) m_mode = 0;
      else if (rise) begin m_mode = 2; m_game = 1; m_cnt = 0; end
    end
    if (acc) begin m_shadow = per; m_pend = 1; end
    m_gclk ^= m_game;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit p, input bit s, input bit v, input int per);
    pause_req = p; step_req = s; cfg_valid = v; cfg_period = per;
    @(posedge clk);
    model_step(p, s, v, per);
    #1;
    chk("pix_tick", pix_tick, m_cyc % PIX_DIV == 0);
    chk("seg_tick", seg_tick, m_cyc % SEG_DIV == 0);
    chk("game_tick", game_tick, m_game);
    chk("paused", paused, m_mode != 0);
    chk("cfg_pending", cfg_pending, m_pend);
    chk("cfg_ready", cfg_ready, !m_pend);
`ifdef TICK_CLKOUT_EN
    chk("dclk", dclk, (m_cyc % PIX_DIV) >= PIX_DIV / 2);
    chk("segclk", segclk, (m_cyc % SEG_DIV) >= SEG_DIV / 2);
    chk("gameclk", gameclk, m_gclk);
`endif
  endtask

  task automatic do_reset();
    pause_req = 0; step_req = 0; cfg_valid = 0; cfg_period = '0;
    @(negedge clk);
    clr_n = 0;
    #1;
    chk("rst_pix_tick", pix_tick, 0);
    chk("rst_seg_tick", seg_tick, 0);
    chk("rst_game_tick", game_tick, 0);
    chk("rst_paused", paused, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_cfg_pending", cfg_pending, 0);
`ifdef TICK_CLKOUT_EN
    chk("rst_dclk", dclk, 0);
    chk("rst_segclk", segclk, 0);
    chk("rst_gameclk", gameclk, 0);
`endif
    @(negedge clk);
    clr_n = 1;
    model_reset();
  endtask

  // Edges until the next game_tick with pause released; 0 if none within the bound.
  task automatic edges_to_tick(output int k);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      cyc(0, 0, 0, 0);
      if (game_tick) k = i;
    end
  endtask

  typedef struct {
    int n; bit p; bit s; bit v; int per; int ticks; bit pz; bit pend;
  } row_t;
  row_t rows[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, cnt;
    bit rp;
    // n, pause, step (held for the row), valid (first cycle only), period, ticks, paused, pending
    rows[0]  = '{100, 0, 0, 0, 0, 10, 0, 0};
    rows[1]  = '{5,   0, 0, 1, 3, 0,  0, 1};
    rows[2]  = '{20,  0, 0, 0, 0, 4,  0, 0};
    rows[3]  = '{20,  1, 0, 0, 0, 0,  1, 0};
    rows[4]  = '{1,   0, 0, 0, 0, 0,  0, 0};
    rows[5]  = '{1,   0, 0, 0, 0, 1,  0, 0};
    rows[6]  = '{2,   1, 0, 0, 0, 0,  1, 0};
    rows[7]  = '{10,  1, 1, 0, 0, 1,  1, 0};
    rows[8]  = '{3,   1, 0, 0, 0, 0,  1, 0};
    rows[9]  = '{3,   1, 1, 0, 0, 1,  1, 0};
    rows[10] = '{2,   1, 0, 0, 0, 0,  1, 0};
    rows[11] = '{2,   1, 1, 0, 0, 1,  1, 0};
    rows[12] = '{2,   1, 0, 1, 0, 0,  1, 0};
    rows[13] = '{5,   0, 0, 0, 0, 4,  0, 0};

    do_reset();
    edges_to_tick(k);
    chk("first_game_tick_edge", k, 10);

    do_reset();
    for (int r = 0; r < 14; r++) begin
      cnt = 0;
      for (int i = 0; i < rows[r].n; i++) begin
        cyc(rows[r].p, rows[r].s, (i == 0) && rows[r].v, rows[r].per);
        cnt += int'(game_tick);
      end
      chk($sformatf("row%0d_ticks", r), cnt, rows[r].ticks);
      chk($sformatf("row%0d_paused", r), paused, rows[r].pz);
      chk($sformatf("row%0d_pending", r), cfg_pending, rows[r].pend);
    end

    // Period 0 is active; leave a config pending, then reset mid-stream: period returns to 9.
    cyc(0, 0, 1, 2);
    chk("pending_before_reset", cfg_pending, 1);
    do_reset();
    edges_to_tick(k);
    chk("tick_after_midreset", k, 10);

    // Pause with gcnt=5 for 20 cycles; the count includes the edge that resumes RUN.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0);
    chk("paused_hold", paused, 1);
    edges_to_tick(k);
    chk("tick_after_resume", k, 6);

    rp = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) rp = !rp;
      cyc(rp, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 12));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
